// File: rtl/seq_pkg.sv
// Shared types and constants for the microprogram sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_NZ     = 2'b10;
    localparam logic [1:0] COND_NEXT   = 2'b11;

    localparam int DEF_UCODE_DEPTH = 75;
    localparam int DEF_HALT_ADDR   = 74;

endpackage

// File: rtl/seq_next_addr.sv
// Combinational next-address selection with halt detection and range-abort.
module seq_next_addr
    import seq_pkg::*;
#(
    parameter int UPC_W       = 7,
    parameter int OPC_W       = 8,
    parameter int UCODE_DEPTH = DEF_UCODE_DEPTH,
    parameter int HALT_ADDR   = DEF_HALT_ADDR
) (
    input  logic [UPC_W-1:0] upc,
    input  logic             bt,
    input  logic [1:0]       condition,
    input  logic [UPC_W-1:0] jump_addr,
    input  logic             z_flag,
    input  logic [OPC_W-1:0] ir_opcode,
    output logic [UPC_W-1:0] next_upc,
    output logic             halt,
    output logic             abort
);

    localparam logic [UPC_W-1:0] HALT_U    = UPC_W'(HALT_ADDR);
    localparam logic [UPC_W:0]   DEPTH_U   = (UPC_W+1)'(UCODE_DEPTH);
    localparam logic [OPC_W:0]   DEPTH_OPC = (OPC_W+1)'(UCODE_DEPTH);

    // One extra bit so uPC+1 can be range-checked instead of wrapping.
    logic [UPC_W:0] upc_inc;
    logic [UPC_W:0] jump_ext;
    logic [UPC_W:0] target;

    assign upc_inc  = {1'b0, upc} + (UPC_W+1)'(1);
    assign jump_ext = {1'b0, jump_addr};

    always_comb begin
        next_upc = upc;
        halt     = 1'b0;
        abort    = 1'b0;
        target   = jump_ext;
        if (upc == HALT_U) begin
            halt = 1'b1;
        end else if (bt) begin
            if ({1'b0, ir_opcode} < DEPTH_OPC) begin
                next_upc = ir_opcode[UPC_W-1:0];
            end else begin
                abort = 1'b1;
            end
        end else begin
            case (condition)
                COND_ALWAYS: target = jump_ext;
                COND_Z:      target = z_flag  ? jump_ext : upc_inc;
                COND_NZ:     target = !z_flag ? jump_ext : upc_inc;
                default:     target = upc_inc;
            endcase
            if (target >= DEPTH_U) begin
                abort = 1'b1;
            end else begin
                next_upc = target[UPC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: state/uPC registers; performance counters built only when SEQ_PERF_CNT_EN is defined.
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int UPC_W       = 7,
    parameter int ADDR_OUT_W  = 16,
    parameter int UCODE_DEPTH = DEF_UCODE_DEPTH,
    parameter int HALT_ADDR   = DEF_HALT_ADDR,
    parameter int OPC_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  z_flag,
    input  logic [OPC_W-1:0]      ir_opcode,
    input  logic                  bt,
    input  logic [1:0]            condition,
    input  logic [UPC_W-1:0]      jump_addr,
    output logic [ADDR_OUT_W-1:0] upc,
    output logic                  op_valid,
    output logic                  done,
    output logic                  illegal_op,
    output logic [31:0]           cycle_cnt,
    output logic [15:0]           dispatch_cnt
);

    seq_state_t       state_reg, state_next;
    logic [UPC_W-1:0] upc_reg, upc_next;
    logic             done_reg, done_next;
    logic             illegal_reg, illegal_next;
    logic [UPC_W-1:0] na_upc;
    logic             na_halt;
    logic             na_abort;

    seq_next_addr #(
        .UPC_W       (UPC_W),
        .OPC_W       (OPC_W),
        .UCODE_DEPTH (UCODE_DEPTH),
        .HALT_ADDR   (HALT_ADDR)
    ) u_next_addr (
        .upc       (upc_reg),
        .bt        (bt),
        .condition (condition),
        .jump_addr (jump_addr),
        .z_flag    (z_flag),
        .ir_opcode (ir_opcode),
        .next_upc  (na_upc),
        .halt      (na_halt),
        .abort     (na_abort)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            upc_reg     <= '0;
            done_reg    <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            upc_reg     <= upc_next;
            done_reg    <= done_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        upc_next     = upc_reg;
        done_next    = done_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    upc_next   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (na_halt) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (na_abort) begin
                        state_next   = DONE;
                        done_next    = 1'b1;
                        illegal_next = 1'b1;
                    end else begin
                        upc_next = na_upc;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_next   = RUN;
                    upc_next     = '0;
                    done_next    = 1'b0;
                    illegal_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign upc        = {{(ADDR_OUT_W-UPC_W){1'b0}}, upc_reg};
    assign op_valid   = (state_reg == RUN) && !stall;
    assign done       = done_reg;
    assign illegal_op = illegal_reg;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_reg;
    logic [15:0] dispatch_cnt_reg;
    logic        cnt_clear;
    logic        dispatch_fire;

    assign cnt_clear     = start && (state_reg != RUN);
    assign dispatch_fire = op_valid && bt && !na_halt && !na_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg    <= '0;
            dispatch_cnt_reg <= '0;
        end else if (cnt_clear) begin
            cycle_cnt_reg    <= '0;
            dispatch_cnt_reg <= '0;
        end else begin
            if (op_valid && !(&cycle_cnt_reg)) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end
            if (dispatch_fire && !(&dispatch_cnt_reg)) begin
                dispatch_cnt_reg <= dispatch_cnt_reg + 16'd1;
            end
        end
    end

    assign cycle_cnt    = cycle_cnt_reg;
    assign dispatch_cnt = dispatch_cnt_reg;
`else
    assign cycle_cnt    = '0;
    assign dispatch_cnt = '0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer; counter expectations follow SEQ_PERF_CNT_EN.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        z_flag = 1'b0;
    logic [7:0]  ir_opcode = '0;
    logic        bt = 1'b0;
    logic [1:0]  condition = 2'b11;
    logic [6:0]  jump_addr = '0;
    logic [15:0] upc;
    logic        op_valid;
    logic        done;
    logic        illegal_op;
    logic [31:0] cycle_cnt;
    logic [15:0] dispatch_cnt;

    micro_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .z_flag       (z_flag),
        .ir_opcode    (ir_opcode),
        .bt           (bt),
        .condition    (condition),
        .jump_addr    (jump_addr),
        .upc          (upc),
        .op_valid     (op_valid),
        .done         (done),
        .illegal_op   (illegal_op),
        .cycle_cnt    (cycle_cnt),
        .dispatch_cnt (dispatch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] upc;
        logic        done;
        logic        ill;
        logic [31:0] cyc;
        logic [15:0] disp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    int   exec_words = 0;

    // Reference model: 0 = IDLE, 1 = RUN, 2 = DONE
    int          m_state = 0;
    int          m_upc   = 0;
    logic        m_done  = 1'b0;
    logic        m_ill   = 1'b0;
    logic [31:0] m_cyc   = '0;
    logic [15:0] m_disp  = '0;

    task automatic model_reset();
        m_state = 0; m_upc = 0; m_done = 1'b0; m_ill = 1'b0;
        m_cyc = '0; m_disp = '0; exec_words = 0;
    endtask

    task automatic model_step(input logic st, input logic stl, input logic b,
                              input logic [1:0] c, input logic [6:0] ja,
                              input logic zf, input logic [7:0] op);
        int t;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_upc = 0; m_done = 1'b0; m_ill = 1'b0;
                m_cyc = '0; m_disp = '0; exec_words = 0;
            end
        end else if (!stl) begin
            exec_words++;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (m_upc == 74) begin
                m_state = 2; m_done = 1'b1;
            end else if (b) begin
                if (op < 75) begin
                    m_upc = op;
                    if (m_disp != 16'hFFFF) m_disp = m_disp + 1;
                end else begin
                    m_state = 2; m_done = 1'b1; m_ill = 1'b1;
                end
            end else begin
                case (c)
                    2'b00:   t = ja;
                    2'b01:   t = zf ? int'(ja) : m_upc + 1;
                    2'b10:   t = !zf ? int'(ja) : m_upc + 1;
                    default: t = m_upc + 1;
                endcase
                if (t >= 75) begin
                    m_state = 2; m_done = 1'b1; m_ill = 1'b1;
                end else begin
                    m_upc = t;
                end
            end
        end
    endtask

    task automatic drive(input logic st, input logic stl, input logic b,
                         input logic [1:0] c, input logic [6:0] ja,
                         input logic zf, input logic [7:0] op);
        exp_t e;
        exp_t g;
        logic exp_opv;
        @(negedge clk);
        start = st; stall = stl; bt = b; condition = c;
        jump_addr = ja; z_flag = zf; ir_opcode = op;
        #1;
        exp_opv = (m_state == 1) && !stl;
        n_checks++;
        if (op_valid !== exp_opv) begin
            n_fail++;
            $display("FAIL op_valid txn %0d: got %b want %b", n_txn, op_valid, exp_opv);
        end
        model_step(st, stl, b, c, ja, zf, op);
        e.upc  = 16'(m_upc);
        e.done = m_done;
        e.ill  = m_ill;
`ifdef SEQ_PERF_CNT_EN
        e.cyc  = m_cyc;
        e.disp = m_disp;
`else
        e.cyc  = '0;
        e.disp = '0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        n_checks++;
        if (upc !== g.upc) begin
            n_fail++;
            $display("FAIL upc txn %0d: got %0d want %0d", n_txn, upc, g.upc);
        end
        n_checks++;
        if (done !== g.done || illegal_op !== g.ill) begin
            n_fail++;
            $display("FAIL flags txn %0d: done/illegal got %b%b want %b%b",
                     n_txn, done, illegal_op, g.done, g.ill);
        end
        n_checks++;
        if (cycle_cnt !== g.cyc || dispatch_cnt !== g.disp) begin
            n_fail++;
            $display("FAIL counters txn %0d: got %0d/%0d want %0d/%0d",
                     n_txn, cycle_cnt, dispatch_cnt, g.cyc, g.disp);
        end
        $display("txn %0d st=%b stall=%b bt=%b cond=%0d ja=%0d z=%b op=%0d -> upc=%0d done=%b ill=%b",
                 n_txn, st, stl, b, c, ja, zf, op, upc, done, illegal_op);
        n_txn++;
    endtask

    task automatic jump_to(input logic [6:0] a);
        drive(1'b0, 1'b0, 1'b0, 2'b00, a, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (upc !== 16'd0 || op_valid !== 1'b0 || done !== 1'b0 || illegal_op !== 1'b0 ||
            cycle_cnt !== 32'd0 || dispatch_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: upc=%0d opv=%b done=%b ill=%b cyc=%0d disp=%0d",
                     upc, op_valid, done, illegal_op, cycle_cnt, dispatch_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd9, 1'b0, 8'd0);
    endtask

    task automatic test_start();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd1, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd1, 1'b0, 8'd0);
        n_checks++;
        if (upc !== 16'd1) begin
            n_fail++;
            $display("FAIL start_first_jump: got %0d want 1", upc);
        end
    endtask

    task automatic test_dispatch();
        jump_to(7'd2);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 7'd40, 1'b1, 8'd11);
        n_checks++;
        if (upc !== 16'd11) begin
            n_fail++;
            $display("FAIL dispatch_target: got %0d want 11", upc);
        end
        jump_to(7'd2);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 7'd3, 1'b0, 8'd80);
        n_checks++;
        if (upc !== 16'd2 || done !== 1'b1 || illegal_op !== 1'b1) begin
            n_fail++;
            $display("FAIL dispatch_illegal: upc=%0d done=%b ill=%b want 2 1 1", upc, done, illegal_op);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd5, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd5, 1'b0, 8'd0);
        n_checks++;
        if (upc !== 16'd0 || done !== 1'b0 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_after_abort: upc=%0d done=%b ill=%b", upc, done, illegal_op);
        end
    endtask

    task automatic test_conditional();
        jump_to(7'd66);
        drive(1'b0, 1'b0, 1'b0, 2'b01, 7'd69, 1'b1, 8'd0);
        n_checks++;
        if (upc !== 16'd69) begin
            n_fail++;
            $display("FAIL cond_z_taken: got %0d want 69", upc);
        end
        jump_to(7'd66);
        drive(1'b0, 1'b0, 1'b0, 2'b01, 7'd69, 1'b0, 8'd0);
        n_checks++;
        if (upc !== 16'd67) begin
            n_fail++;
            $display("FAIL cond_z_fall: got %0d want 67", upc);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b10, 7'd20, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 2'b10, 7'd50, 1'b1, 8'd0);
        n_checks++;
        if (upc !== 16'd21) begin
            n_fail++;
            $display("FAIL cond_nz_fall: got %0d want 21", upc);
        end
    endtask

    task automatic test_stall();
        jump_to(7'd5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 2'b00, 7'd60, 1'b0, 8'd0);
            n_checks++;
            if (upc !== 16'd5) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got %0d want 5", i, upc);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 2'b11, 7'd60, 1'b0, 8'd0);
        n_checks++;
        if (upc !== 16'd6) begin
            n_fail++;
            $display("FAIL stall_release: got %0d want 6", upc);
        end
    endtask

    task automatic test_halt_restart();
        jump_to(7'd73);
        drive(1'b0, 1'b0, 1'b0, 2'b11, 7'd0, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 1'b1, 2'b00, 7'd0, 1'b0, 8'd90);
        drive(1'b0, 1'b0, 1'b1, 2'b00, 7'd0, 1'b0, 8'd90);
        n_checks++;
        if (done !== 1'b1 || illegal_op !== 1'b0 || op_valid !== 1'b0 || upc !== 16'd74) begin
            n_fail++;
            $display("FAIL halt: done=%b ill=%b opv=%b upc=%0d", done, illegal_op, op_valid, upc);
        end
        n_checks++;
`ifdef SEQ_PERF_CNT_EN
        if (cycle_cnt !== 32'(exec_words)) begin
            n_fail++;
            $display("FAIL halt_cycle_cnt: got %0d want %0d", cycle_cnt, exec_words);
        end
`else
        if (cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL halt_cycle_cnt: got %0d want 0", cycle_cnt);
        end
`endif
        drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 1'b0, 8'd0);
        n_checks++;
        if (upc !== 16'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart: upc=%0d done=%b", upc, done);
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd100, 1'b0, 8'd0);
        n_checks++;
        if (illegal_op !== 1'b1 || upc !== 16'd0) begin
            n_fail++;
            $display("FAIL jump_range: ill=%b upc=%0d", illegal_op, upc);
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 1'b0, 8'd0);
    endtask

    task automatic test_back_to_back();
        logic       st, stl, b, zf;
        logic [1:0] c;
        logic [6:0] ja;
        logic [7:0] op;
        for (int i = 0; i < 60; i++) begin
            st  = ($urandom_range(0, 7) == 0);
            stl = ($urandom_range(0, 4) == 0);
            b   = ($urandom_range(0, 3) == 0);
            zf  = 1'($urandom);
            c   = 2'($urandom);
            ja  = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(75, 127))
                                               : 7'($urandom_range(0, 74));
            op  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(75, 255))
                                              : 8'($urandom_range(0, 74));
            drive(st, stl, b, c, ja, zf, op);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 7'd30, 1'b0, 8'd0);
        jump_to(7'd30);
        n_checks++;
        if (upc !== 16'd30) begin
            n_fail++;
            $display("FAIL async_setup: got %0d want 30", upc);
        end
        stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (upc !== 16'd0 || op_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: upc=%0d opv=%b done=%b", upc, op_valid, done);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 7'd12, 1'b0, 8'd0);
    endtask

    initial begin
        fork
            begin
                #200000;
                n_fail++;
                $display("FAIL timeout: simulation exceeded time budget");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_start();
        test_dispatch();
        test_conditional();
        test_stall();
        test_halt_restart();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for each core's control unit. It holds the micro-program counter (uPC), drives the microcode ROM address, and chooses the next address from the ROM's control fields (BT, condition, jump_addr), the ALU zero flag and the instruction-register opcode. It sits directly upstream of the microcode ROM and consumes the ROM's control outputs in the same cycle, because the ROM is combinational.

## Interface
- UPC_W, 7: uPC register width.
- ADDR_OUT_W, 16: width of the ROM address output.
- UCODE_DEPTH, 75: number of valid microcode words.
- HALT_ADDR, 74: microinstruction that ends a program.
- OPC_W, 8: opcode width from the instruction register.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  launch or relaunch the program; level-sampled.
- stall  in  1  hold the current microinstruction (memory/bus wait).
- z_flag  in  1  ALU zero flag.
- ir_opcode  in  OPC_W  opcode from the instruction register, used by dispatch.
- bt  in  1  ROM dispatch bit.
- condition  in  2  ROM branch condition.
- jump_addr  in  UPC_W  ROM next/branch address.
- upc  out  ADDR_OUT_W  ROM address; the uPC zero-extended.
- op_valid  out  1  ROM OPs are to be executed this cycle.
- done  out  1  program finished or aborted.
- illegal_op  out  1  sticky abort flag.
- cycle_cnt  out  32  RUN-cycle count (see Configuration).
- dispatch_cnt  out  16  count of executed dispatches (see Configuration).

## Operation
- States:
  - IDLE: after reset; uPC=0.
  - RUN.
  - DONE.
- IDLE→RUN when start=1. uPC stays 0, so word 0 executes in the first RUN cycle.
- op_valid = (state==RUN) && !stall.
- When RUN and stall=1: uPC, state and counters hold. The stalled word issues when stall falls, and its branch uses the flags sampled in that cycle.
- When RUN and !stall, next-address priority is:
  1. uPC==HALT_ADDR: go to DONE, uPC holds, done=1.
  2. bt=1 (dispatch; condition is ignored):
     - ir_opcode<UCODE_DEPTH: uPC = ir_opcode[UPC_W-1:0].
     - otherwise: go to DONE with illegal_op=1 and done=1.
  3. condition 00: uPC = jump_addr. A jump_addr of 0 returns to fetch.
  4. condition 01: uPC = z_flag ? jump_addr : uPC+1.
  5. condition 10: uPC = !z_flag ? jump_addr : uPC+1.
  6. condition 11: uPC = uPC+1.
- Range checks:
  - Any computed uPC+1 ≥ UCODE_DEPTH, or jump_addr ≥ UCODE_DEPTH, aborts to DONE with illegal_op=1.
  - uPC never wraps.
- DONE:
  - uPC holds and op_valid=0.
  - start=1 sets uPC=0, state RUN, and clears done and illegal_op.
- start is ignored in RUN.

## Timing
- Reset values: upc=0, state IDLE, op_valid=0, done=0, illegal_op=0, cycle_cnt=0, dispatch_cnt=0.
- Asserting rst_n=0 clears everything immediately, including mid-RUN.
- Next-address decision is combinational on the current ROM fields. uPC updates on the next rising edge, giving one microinstruction per cycle and 1-cycle branch/dispatch latency with no bubble.
- done and illegal_op are registered and assert on the edge that enters DONE.
- When stall and halt/branch conditions occur together, stall wins.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_cnt increments on each RUN cycle where !stall.
  - dispatch_cnt increments on each executed dispatch.
  - Both counters saturate and clear on start from IDLE or DONE.
- SEQ_PERF_CNT_EN undefined: no counter registers are built; both outputs are tied to 0.

## Structure
- Package seq_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - Condition encodings: COND_ALWAYS=00, COND_Z=01, COND_NZ=10, COND_NEXT=11.
  - Defaults for UCODE_DEPTH and HALT_ADDR.
- Sub-module seq_next_addr: purely combinational next-address and abort decision from uPC, bt, condition, jump_addr, z_flag and ir_opcode.
- The top level keeps the state register, uPC register and counters.

## Test plan
- Reset/start: release rst_n → upc=0, op_valid=0. Pulse start → next cycle op_valid=1, upc=0. With bt=0, cond=00, jump_addr=1 → upc=1 one cycle later.
- Dispatch:
  - upc=2, bt=1, ir_opcode=11 → upc=11.
  - ir_opcode=80 → done=1, illegal_op=1, upc holds 2.
- Conditional: upc=66, cond=01, jump_addr=69:
  - z_flag=1 → upc=69.
  - Rerun with z_flag=0 → upc=67.
- Stall: stall=1 for 3 cycles at upc=5 → upc stays 5 and op_valid=0 throughout. On release, upc advances per the ROM fields.
- Halt/restart:
  - Reach upc=74 → next cycle done=1, op_valid=0; with SEQ_PERF_CNT_EN, cycle_cnt equals the executed word count.
  - start → upc=0, RUN, done=0.
- Async reset: rst_n low at upc=30 mid-RUN → upc=0 and IDLE immediately, without waiting for an edge.
